// File: rtl/store_buffer_if.sv
// Bundles the MEM-stage store/load request side and the memory data port of
// the posted-write store buffer. The slave modport is the buffer's view; the
// master modport is the view of whoever drives the pipeline and the memory model.
interface store_buffer_if #(
    parameter int CW = 3
);
    // MEM-stage store request
    logic          st_req;
    logic [31:0]   st_addr;
    logic [3:0]    st_sel;
    logic [31:0]   st_data;
    // MEM-stage load request and result
    logic          ld_req;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_data;
    // Pipeline hold request
    logic          stall_req;
    // Memory data port
    logic          mem_rdy;
    logic          mem_ce;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [3:0]    mem_sel;
    logic [31:0]   mem_data_o;
    logic [31:0]   mem_data_i;
    // Buffer fill level
    logic [CW-1:0] occupancy;

    modport slave (
        input  st_req, st_addr, st_sel, st_data,
        input  ld_req, ld_addr,
        input  mem_rdy, mem_data_i,
        output ld_data, stall_req,
        output mem_ce, mem_we, mem_addr, mem_sel, mem_data_o,
        output occupancy
    );

    modport master (
        output st_req, st_addr, st_sel, st_data,
        output ld_req, ld_addr,
        output mem_rdy, mem_data_i,
        input  ld_data, stall_req,
        input  mem_ce, mem_we, mem_addr, mem_sel, mem_data_o,
        input  occupancy
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer. Stores are queued in a small FIFO and drained to
// the memory port whenever it is not busy with a load. Loads go straight to
// memory unless a still-queued store targets the same word, in which case the
// pipeline is held until that store has drained.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);
    localparam int            AW       = CW - 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Word-granular address compare used by the load hazard check
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return (a[31:2] == b[31:2]);
    endfunction

    // Entry storage and FIFO bookkeeping
    logic [31:0]   addr_q  [DEPTH];
    logic [31:0]   addr_d  [DEPTH];
    logic [3:0]    sel_q   [DEPTH];
    logic [3:0]    sel_d   [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [31:0]   data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [AW-1:0] head_q;
    logic [AW-1:0] head_d;
    logic [AW-1:0] tail_q;
    logic [AW-1:0] tail_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Control decodes
    logic full_s;
    logic empty_s;
    logic hazard_s;
    logic load_srv_s;
    logic drain_s;
    logic push_s;
    logic pop_s;

    // Decode full/empty from the registered count and look for a load hazard
    always_comb begin
        full_s   = (count_q == FULL_CNT);
        empty_s  = (count_q == {CW{1'b0}});
        hazard_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.ld_req && valid_q[i] && word_match(addr_q[i], bus.ld_addr)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Port arbitration: a clean load wins, otherwise drain the head entry
    always_comb begin
        load_srv_s = bus.ld_req && !hazard_s;
        drain_s    = !empty_s && !load_srv_s;
        pop_s      = drain_s && bus.mem_rdy;
        // A store alongside a load is never enqueued; the pipeline must retry it
        push_s     = bus.st_req && !bus.ld_req && !full_s;
    end

    // Next-state for entries, pointers and count
    always_comb begin
        addr_d  = addr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_s) begin
            addr_d[tail_q]  = bus.st_addr;
            sel_d[tail_q]   = bus.st_sel;
            data_d[tail_q]  = bus.st_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end else begin
            tail_d = tail_q;
        end
        // Push and pop never hit the same slot: push needs not-full, pop needs not-empty
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous active-low reset; pending stores are discarded
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 32'h0000_0000;
                sel_q[i]  <= 4'b0000;
                data_q[i] <= 32'h0000_0000;
            end
            valid_q <= {DEPTH{1'b0}};
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Memory port, load result and stall; everything forced idle while in reset
    always_comb begin
        bus.mem_ce     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 32'h0000_0000;
        bus.mem_sel    = 4'b0000;
        bus.mem_data_o = 32'h0000_0000;
        bus.ld_data    = 32'h0000_0000;
        bus.stall_req  = 1'b0;
        bus.occupancy  = {CW{1'b0}};
        if (!rst) begin
            bus.mem_ce = 1'b0;
        end else begin
            bus.occupancy = count_q;
            bus.stall_req = (bus.st_req && full_s) ||
                            (bus.st_req && bus.ld_req) ||
                            (bus.ld_req && hazard_s);
            if (load_srv_s) begin
                bus.mem_ce   = 1'b1;
                bus.mem_we   = 1'b0;
                bus.mem_addr = bus.ld_addr;
                bus.mem_sel  = 4'b1111;
                bus.ld_data  = bus.mem_data_i;
            end else if (drain_s) begin
                bus.mem_ce     = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = addr_q[head_q];
                bus.mem_sel    = sel_q[head_q];
                bus.mem_data_o = data_q[head_q];
            end else begin
                bus.mem_ce = 1'b0;
            end
        end
    end
endmodule
